// File: rtl/ct_f_spsram_param_pkg.sv
// Shared definitions for the parametrised single-port SRAM model.
package ct_f_spsram_param_pkg;

    // Init walker state: INIT zero-fills the array, READY serves requests.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    // Number of independently write-masked storage slices.
    function automatic int seg_count(input int data_width, input int seg_width);
        return data_width / seg_width;
    endfunction

endpackage

// File: rtl/fpga_ram.sv
// Single-port synchronous RAM primitive; read-first, registered output.
module fpga_ram #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  PortAClk,
    input  logic [ADDR_WIDTH-1:0] PortAAddr,
    input  logic [DATA_WIDTH-1:0] PortADataIn,
    input  logic                  PortAWriteEnable,
    output logic [DATA_WIDTH-1:0] PortADataOut
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write on enable; the addressed word is read out every cycle.
    always_ff @(posedge PortAClk) begin
        if (PortAWriteEnable) begin
            mem[PortAAddr] <= PortADataIn;
        end
        PortADataOut <= mem[PortAAddr];
    end

endmodule

// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM built from one fpga_ram per write-mask
// segment, with an optional zero-fill walker and optional output register.
module ct_f_spsram_param
    import ct_f_spsram_param_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 22,
    parameter int SEG_WIDTH  = 11,
    parameter bit INIT_EN    = 1'b1,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_BUSY
);

    localparam int NSEG = seg_count(DATA_WIDTH, SEG_WIDTH);

    if (DATA_WIDTH % SEG_WIDTH != 0) begin : g_bad_geometry
        $error("ct_f_spsram_param: DATA_WIDTH must be a multiple of SEG_WIDTH");
    end

    logic                  init_busy;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  acc_en;
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] raw_q_p0;
    logic                  unused_wen;

    if (INIT_EN) begin : g_init
        init_state_e state;

        // Walk every address once after reset, then stay READY.
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
                state    <= INIT;
                init_cnt <= '0;
            end else if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (&init_cnt) begin
                    state <= READY;
                end
            end
        end

        assign init_busy = (state == INIT);
    end else begin : g_no_init
        assign init_busy = 1'b0;
        assign init_cnt  = '0;
    end

    assign INIT_BUSY = init_busy;

    // Requests seen during the walk are dropped, never queued.
    assign acc_en = !CEN && !init_busy;
    assign wr_acc = acc_en && !GWEN;

    // Only segment MSBs of WEN act as enables; the other bits carry no meaning.
    assign unused_wen = ^WEN;

    // Remember the last accessed address so Q stays put while deselected.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            addr_hold <= '0;
        end else if (acc_en) begin
            addr_hold <= A;
        end
    end

    assign ram_addr = init_busy ? init_cnt : (acc_en ? A : addr_hold);

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        logic                 seg_wen;
        logic [SEG_WIDTH-1:0] seg_din;

        assign seg_wen = init_busy || (wr_acc && !WEN[s*SEG_WIDTH+SEG_WIDTH-1]);
        assign seg_din = init_busy ? '0 : D[s*SEG_WIDTH +: SEG_WIDTH];

        fpga_ram #(
            .DATA_WIDTH (SEG_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .PortAClk         (CLK),
            .PortAAddr        (ram_addr),
            .PortADataIn      (seg_din),
            .PortAWriteEnable (seg_wen),
            .PortADataOut     (raw_q_p0[s*SEG_WIDTH +: SEG_WIDTH])
        );
    end

    if (OUT_REG) begin : g_out_reg
        logic                  rd_vld;
        logic [DATA_WIDTH-1:0] q_p1;

        // Flag that the RAM output carries fresh read data this cycle.
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
                rd_vld <= 1'b0;
            end else begin
                rd_vld <= acc_en && GWEN;
            end
        end

        // ---- stage p1: capture read data, hold across writes and idles ----
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
                q_p1 <= '0;
            end else if (rd_vld) begin
                q_p1 <= raw_q_p0;
            end
        end

        assign Q = q_p1;
    end else begin : g_out_raw
        assign Q = raw_q_p0;
    end

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Bench for ct_f_spsram_param: drives one unregistered and one registered
// instance with identical stimulus and checks both against a word-level model.
module tb_ct_f_spsram_param;

    localparam int AW    = 9;
    localparam int DW    = 22;
    localparam int SW    = 11;
    localparam int DEPTH = 512;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          CEN, GWEN;
    logic [DW-1:0] WEN, D;
    logic [AW-1:0] A;
    logic [DW-1:0] q0, q1;
    logic          busy0, busy1;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    ct_f_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_WIDTH(SW),
                        .INIT_EN(1'b1), .OUT_REG(1'b0)) dut0 (
        .CLK(CLK), .cpurst_b(rst_n), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
        .A(A), .D(D), .Q(q0), .INIT_BUSY(busy0));

    ct_f_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_WIDTH(SW),
                        .INIT_EN(1'b1), .OUT_REG(1'b1)) dut1 (
        .CLK(CLK), .cpurst_b(rst_n), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
        .A(A), .D(D), .Q(q1), .INIT_BUSY(busy1));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m [DEPTH];
    int            init_left;
    logic [DW-1:0] exp0, exp1;
    bit            vld0;
    bit            prev_rd;

    function automatic logic [DW-1:0] seg_mask(input logic [DW-1:0] wen);
        logic [DW-1:0] m;
        m = '0;
        for (int s = 0; s < DW/SW; s++) begin
            if (!wen[s*SW+SW-1]) m[s*SW +: SW] = '1;
        end
        return m;
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] <= '0;
            init_left <= DEPTH;
            vld0      <= 1'b0;
            exp0      <= '0;
            exp1      <= '0;
            prev_rd   <= 1'b0;
        end else begin
            prev_rd <= 1'b0;
            if (init_left > 0) begin
                init_left <= init_left - 1;
            end else if (!CEN) begin
                if (GWEN) begin
                    exp0    <= mem_m[A];
                    vld0    <= 1'b1;
                    prev_rd <= 1'b1;
                end else begin
                    mem_m[A] <= (mem_m[A] & ~seg_mask(WEN)) | (D & seg_mask(WEN));
                    vld0     <= 1'b0;
                end
            end
            if (prev_rd) exp1 <= exp0;
        end
    end

    // Compare every cycle outside reset.
    always @(negedge CLK) begin
        if (rst_n) begin
            chk("busy0", 32'(busy0), 32'(init_left != 0));
            chk("busy1", 32'(busy1), 32'(init_left != 0));
            if (vld0) chk("q0_model", 32'(q0), 32'(exp0));
            chk("q1_model", 32'(q1), 32'(exp1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic cen, input logic gwen, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] wen);
        @(negedge CLK);
        CEN = cen; GWEN = gwen; A = a; D = d; WEN = wen;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b0, 1'b1, a, '0, '1);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
        drive(1'b0, 1'b0, a, d, wen);
    endtask

    task automatic idle(input logic [AW-1:0] a);
        drive(1'b1, 1'b1, a, '0, '1);
    endtask

    // Count cycles with INIT_BUSY high; called on the release edge.
    task automatic wait_init(input string name);
        int cnt;
        cnt = 0;
        while (busy0 && cnt < 2000) begin
            @(negedge CLK);
            cnt++;
        end
        chk(name, 32'(cnt), 32'd512);
        CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0; A = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0; A = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_q1", 32'(q1), 32'd0);

        // Write attempt held during the whole walk must be dropped.
        CEN = 1'b0; GWEN = 1'b0; A = 9'h005; D = 22'h3FFFFF; WEN = '0;
        rst_n = 1'b1;
        wait_init("init_len");

        rd(9'h1FF);
        idle(9'h000); chk("rd1ff_q0", 32'(q0), 32'h0);
        idle(9'h000); chk("rd1ff_q1", 32'(q1), 32'h0);

        rd(9'h005);
        idle(9'h000); chk("drop_q0", 32'(q0), 32'h0);
        idle(9'h000); chk("drop_q1", 32'(q1), 32'h0);

        // Only the low segment enabled.
        wr(9'h010, 22'h3FFFFF, 22'h3FFBFF);
        rd(9'h010);
        idle(9'h000); chk("mask_q0", 32'(q0), 32'h0007FF);
        idle(9'h000); chk("mask_q1", 32'(q1), 32'h0007FF);

        // Address hold with A toggling while deselected.
        wr(9'h020, 22'h123456, 22'h000000);
        rd(9'h020);
        for (int i = 0; i < 6; i++) begin
            idle(AW'((i * 37 + 3) % DEPTH));
            chk("hold_q0", 32'(q0), 32'h123456);
            if (i >= 1) chk("hold_q1", 32'(q1), 32'h123456);
        end

        // Back-to-back writes then reads.
        for (int i = 0; i < 16; i++) wr(AW'(i), 22'h3A0000 | DW'(i * 22'h111), 22'h000000);
        for (int i = 0; i < 16; i++) begin
            rd(AW'(i));
            if (i >= 1) chk("b2b_q0", 32'(q0), 32'h3A0000 | 32'((i - 1) * 32'h111));
        end
        idle(9'h000); chk("b2b_last_q0", 32'(q0), 32'h3A0F00 | 32'h0FF);
        idle(9'h000); chk("b2b_last_q1", 32'(q1), 32'h3A0FFF);
        idle(9'h000);

        // Reset, then reset again with the walker at address 200.
        @(negedge CLK); rst_n = 1'b0;
        @(negedge CLK); rst_n = 1'b1;
        repeat (200) @(negedge CLK);
        chk("mid_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        wait_init("reinit_len");

        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i));
            if (i >= 1) chk("clear_q0", 32'(q0), 32'h0);
        end
        idle(9'h000); chk("clear_last_q0", 32'(q0), 32'h0);
        idle(9'h000); chk("clear_last_q1", 32'(q1), 32'h0);
        repeat (2) idle(9'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ct_f_spsram_param.md
# ct_f_spsram_param

Parametrised FPGA single-port SRAM model for C910 array macros, replacing the fixed-geometry per-macro FPGA models. Depth, data width and write-mask segment width are set by parameters, and storage is split into one `fpga_ram` instance per segment. Unlike the fixed models, it clears all contents to zero after reset through a hardware init walker. An optional output register stage is available for timing closure on large arrays.

## Interface
Parameters:
- ADDR_WIDTH, 9, address bits; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 22, data bits; must be an integer multiple of SEG_WIDTH.
- SEG_WIDTH, 11, write-mask granularity; NSEG = DATA_WIDTH/SEG_WIDTH `fpga_ram` instances.
- INIT_EN, 1, 1 = zero-fill after reset; 0 = no walker, INIT_BUSY tied 0.
- OUT_REG, 0, 1 = extra registered stage on Q.

Ports:
- CLK, in, 1, array clock.
- cpurst_b, in, 1, reset, asynchronous, active-low.
- CEN, in, 1, chip enable, active-low.
- GWEN, in, 1, global write enable, active-low.
- WEN, in, DATA_WIDTH, bit write enable, active-low. Only bit s*SEG_WIDTH+SEG_WIDTH-1 (segment MSB) is sampled for segment s.
- A, in, ADDR_WIDTH, address.
- D, in, DATA_WIDTH, write data.
- Q, out, DATA_WIDTH, read data.
- INIT_BUSY, out, 1, high while the zero-fill walker runs.

## Operation
- Segment s write enable: `seg_wen[s] = !CEN & !GWEN & !WEN[s*SEG_WIDTH+SEG_WIDTH-1] & !INIT_BUSY`.
- Segment s data in: `D[s*SEG_WIDTH +: SEG_WIDTH]`.
- Read access: `!CEN & GWEN`.
- Address holding:
  - `addr_hold` register loads A on every cycle with !CEN and INIT_BUSY=0; reset value 0.
  - Effective address = A when access is enabled; otherwise `addr_hold`.
  - Result: Q stays stable while CEN is high.
- Init FSM (INIT_EN=1), two states:
  - INIT, entered on reset. Counter `init_cnt` (ADDR_WIDTH bits) drives the address; all segments written with zero every cycle. `init_cnt` increments by 1 per cycle.
  - When `init_cnt == 2^ADDR_WIDTH-1`, the write completes and the FSM moves to READY.
  - READY is terminal until the next reset.
- INIT_BUSY = (state==INIT).
- While INIT_BUSY is high, CEN/GWEN/WEN/A/D are ignored. Requests in this window are dropped, not queued.
- Reset mid-init restarts the walker at address 0.
- OUT_REG=1:
  - `rd_vld` flop = read access of the previous cycle.
  - Q register loads the raw `fpga_ram` output when `rd_vld`, and holds otherwise.
  - Q reset value 0.
- OUT_REG=0: Q = raw `fpga_ram` output. Its value is don't-care until the first read completes.

## Timing
- Read latency: data from a read at edge N appears on Q after edge N+1 (OUT_REG=0) or after edge N+2 (OUT_REG=1).
- Write latency: 1 cycle. A read of the same address issued on the next cycle returns the new data.
- Q in the cycle after a write is don't-care. The bench must not check it.
- Back-to-back reads are accepted every cycle. There is no backpressure once READY.
- Init duration: exactly 2^ADDR_WIDTH cycles after reset deassertion. INIT_BUSY falls after the edge that writes the last address.
- First legal access: the cycle after INIT_BUSY falls.
- Reset values: INIT_BUSY = 1 (INIT_EN=1) or 0 (INIT_EN=0); `addr_hold` = 0; `init_cnt` = 0; `rd_vld` = 0; registered Q = 0.

## Structure
- Shared package constants: FSM state encoding (INIT=1'b0, READY=1'b1).
- Sub-module: existing `fpga_ram #(SEG_WIDTH, ADDR_WIDTH)`, instantiated NSEG times in a generate loop.
- No other sub-modules.
- Elaboration check: error if DATA_WIDTH % SEG_WIDTH != 0.
- Expected size: ~150–200 lines.

## Test plan
- Reset release, ADDR_WIDTH=9, INIT_EN=1 -> INIT_BUSY high for exactly 512 cycles. A read of addr 0x1FF afterwards returns 0.
- Write attempt during init (CEN=0, GWEN=0, A=0x005, D=0x3FFFFF) -> dropped. After init, a read of 0x005 returns 0x000000.
- Segment mask, DATA_WIDTH=22/SEG_WIDTH=11:
  - Write 0x3FFFFF to 0x010 with WEN[10]=0, WEN[21]=1.
  - Read 0x010 -> Q = 0x0007FF one cycle later (OUT_REG=0), or two cycles later (OUT_REG=1).
- Address hold: read 0x020 (holding 0x123456 & mask), then CEN=1 for 5 cycles with A toggling -> Q stays at the 0x020 data throughout.
- Reset mid-init: assert cpurst_b low at walker address 200 -> after release, INIT_BUSY high for a fresh 512 cycles. All addresses read 0.
- Back-to-back: writes to 0x000–0x00F, then 16 consecutive reads -> Q sequence matches, one word per cycle, at the configured latency.
